axil_regbank_slave: RTL and testbench

//  Parametrised AXI4-Lite slave in front of a DEPTH-word register bank; next-generation replacement for the fixed 32-bit operand/result slave.

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_regbank.sv | 57 +++++
 rtl/axil_regbank_slave.sv | 192 +++++++++++++++++++
 tb/tb_axil_regbank_slave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared response codes and FSM state types for the AXI4-Lite
//                register-bank slave.
//  Revision    : 1.0
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regbank
//  Description : DEPTH x DATA_W register bank, byte-enabled write port and
//                registered read port; cleared by asynchronous reset.
//  Revision    : 1.0
// ============================================================================
module axil_regbank
    import axil_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                rd_en,
    input  logic                rd_oor,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read samples the array before this edge's write lands, so a same-edge
    // read of the written word returns the old contents.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        r_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
            if (rd_en) begin
                r_rd_data <= rd_oor ? '0 : r_mem[rd_idx];
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axil_regbank_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regbank_slave
//  Description : AXI4-Lite slave fronting a DEPTH-word register bank with
//                independent AW/W capture, byte strobes and SLVERR decode.
//  Revision    : 1.0
// ============================================================================
module axil_regbank_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    input  logic                s_arvalid,
    output logic                s_arready,
    input  logic [ADDR_W-1:0]   s_araddr,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int WORD_W = ADDR_W - LSB;
    localparam int IDX_W  = $clog2(DEPTH);

    wr_state_t           r_wr_state;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [WORD_W-1:0]   r_aw_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    rd_state_t           r_rd_state;
    logic                r_arready;
    logic                r_rvalid;
    logic [1:0]          r_rresp;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_aw_have;
    logic                w_w_have;
    logic                w_wr_fire;
    logic [WORD_W-1:0]   w_wr_word;
    logic [DATA_W-1:0]   w_wr_data;
    logic [STRB_W-1:0]   w_wr_strb;
    logic                w_wr_oor;
    logic                w_ar_hs;
    logic [WORD_W-1:0]   w_ar_word;
    logic                w_ar_oor;
    logic                w_unused_lsbs;

    // In W_IDLE a dropped ready marks that channel as already captured.
    assign w_aw_hs   = s_awvalid && r_awready;
    assign w_w_hs    = s_wvalid && r_wready;
    assign w_aw_have = w_aw_hs || ((r_wr_state == W_IDLE) && !r_awready);
    assign w_w_have  = w_w_hs  || ((r_wr_state == W_IDLE) && !r_wready);
    assign w_wr_fire = (r_wr_state == W_IDLE) && w_aw_have && w_w_have;

    assign w_wr_word = w_aw_hs ? s_awaddr[ADDR_W-1:LSB] : r_aw_word;
    assign w_wr_data = w_w_hs  ? s_wdata : r_wdata;
    assign w_wr_strb = w_w_hs  ? s_wstrb : r_wstrb;

    assign w_ar_hs   = s_arvalid && r_arready;
    assign w_ar_word = s_araddr[ADDR_W-1:LSB];

    assign w_unused_lsbs = ^{s_awaddr[LSB-1:0], s_araddr[LSB-1:0]};

    generate
        if (WORD_W > IDX_W) begin : g_decode
            assign w_wr_oor = |w_wr_word[WORD_W-1:IDX_W];
            assign w_ar_oor = |w_ar_word[WORD_W-1:IDX_W];
        end else begin : g_full_map
            assign w_wr_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate

    axil_regbank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .wr_en   (w_wr_fire && !w_wr_oor),
        .wr_idx  (w_wr_word[IDX_W-1:0]),
        .wr_data (w_wr_data),
        .wr_strb (w_wr_strb),
        .rd_en   (w_ar_hs),
        .rd_oor  (w_ar_oor),
        .rd_idx  (w_ar_word[IDX_W-1:0]),
        .rd_data (s_rdata)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_aw_word  <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_word <= s_awaddr[ADDR_W-1:LSB];
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                        r_wready <= 1'b0;
                    end
                    if (w_wr_fire) begin
                        r_wr_state <= W_RESP;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        r_wr_state <= W_IDLE;
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wready   <= 1'b1;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_state <= R_DATA;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_rd_state <= R_IDLE;
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_regbank_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_regbank_slave
//  Description : Directed self-checking bench for axil_regbank_slave.
//  Revision    : 1.0
// ============================================================================
module tb_axil_regbank_slave;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              s_awvalid, s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid, s_wready;
    logic [DATA_W-1:0] s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_bvalid, s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid, s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid, s_rready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;

    int checks   = 0;
    int failures = 0;

    axil_regbank_slave #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_bresp   (s_bresp),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic send_aw_w(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int  n = 0;
        logic aw_hs, w_hs;
        s_awvalid = 1'b1; s_awaddr = a;
        s_wvalid  = 1'b1; s_wdata  = d; s_wstrb = s;
        do begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge PCLK);
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid  = 1'b0;
            n++;
        end while ((s_awvalid || s_wvalid) && n < 20);
        check("aw_w_accept", {s_awvalid, s_wvalid}, 2'b00);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        while (!s_bvalid && lat < 20) begin
            @(negedge PCLK);
            lat++;
        end
        check("bvalid_seen", s_bvalid, 1'b1);
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge PCLK);
        s_bready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        logic [1:0] resp;
        int         lat;
        send_aw_w(a, d, s);
        wait_b(resp, lat);
        check({tag, "_blat"}, lat, 0);
        check({tag, "_bresp"}, resp, exp_resp);
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        s_arvalid = 1'b1; s_araddr = a;
        while (!s_arready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        @(negedge PCLK);
        s_arvalid = 1'b0;
        check({tag, "_rvalid"}, s_rvalid, 1'b1);
        check({tag, "_rdata"}, s_rdata, exp_data);
        check({tag, "_rresp"}, s_rresp, exp_resp);
        s_rready = 1'b1;
        @(negedge PCLK);
        s_rready = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        int         lat;
        PRESET = 1'b1;
        s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
        s_bready = 0; s_arvalid = 0; s_araddr = '0; s_rready = 0;
        repeat (3) @(negedge PCLK);
        check("rst_awready", s_awready, 1'b1);
        check("rst_wready",  s_wready,  1'b1);
        check("rst_arready", s_arready, 1'b1);
        check("rst_bvalid",  s_bvalid,  1'b0);
        check("rst_rvalid",  s_rvalid,  1'b0);
        check("rst_rdata",   s_rdata,   32'h0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // AW and W together
        do_write("wr_same", 12'h004, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read("rd_same", 12'h004, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW
        s_wvalid = 1'b1; s_wdata = 32'h12345678; s_wstrb = 4'hF;
        @(negedge PCLK);
        s_wvalid = 1'b0;
        check("wfirst_wready", s_wready, 1'b0);
        repeat (2) @(negedge PCLK);
        check("wfirst_bvalid_early", s_bvalid, 1'b0);
        check("wfirst_awready", s_awready, 1'b1);
        s_awvalid = 1'b1; s_awaddr = 12'h008;
        @(negedge PCLK);
        s_awvalid = 1'b0;
        check("wfirst_bvalid", s_bvalid, 1'b1);
        wait_b(resp, lat);
        check("wfirst_bresp", resp, 2'b00);
        do_read("rd_wfirst", 12'h008, 32'h12345678, 2'b00);

        // Byte strobes; address LSBs ignored
        do_write("wr_full", 12'h00C, 32'h11111111, 4'hF, 2'b00);
        do_write("wr_strb", 12'h00E, 32'hAAAAAAAA, 4'b0011, 2'b00);
        do_read("rd_strb", 12'h00C, 32'h1111AAAA, 2'b00);
        do_write("wr_nostrb", 12'h00C, 32'h55555555, 4'b0000, 2'b00);
        do_read("rd_nostrb", 12'h00C, 32'h1111AAAA, 2'b00);

        // Out of range index 16
        do_write("wr_oor", 12'h040, 32'hCAFEF00D, 4'hF, 2'b10);
        do_read("rd_oor", 12'h040, 32'h0, 2'b10);
        do_read("rd_alias0", 12'h000, 32'h0, 2'b00);

        // Backpressure on B
        send_aw_w(12'h040, 32'h1, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("hold_bvalid", s_bvalid, 1'b1);
            check("hold_bresp", s_bresp, 2'b10);
            check("hold_awready", {s_awready, s_wready}, 2'b00);
            @(negedge PCLK);
        end
        s_bready = 1'b1;
        @(negedge PCLK);
        s_bready = 1'b0;
        check("hold_bdone", s_bvalid, 1'b0);
        check("hold_awready_back", {s_awready, s_wready}, 2'b11);

        // Backpressure on R
        s_arvalid = 1'b1; s_araddr = 12'h004;
        @(negedge PCLK);
        s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_rvalid", s_rvalid, 1'b1);
            check("hold_rdata", s_rdata, 32'hDEADBEEF);
            check("hold_rresp", s_rresp, 2'b00);
            check("hold_arready", s_arready, 1'b0);
            @(negedge PCLK);
        end
        s_rready = 1'b1;
        @(negedge PCLK);
        s_rready = 1'b0;
        check("hold_rdone", s_rvalid, 1'b0);

        // Same-edge read and write of word 1
        s_awvalid = 1'b1; s_awaddr = 12'h004; s_wvalid = 1'b1; s_wdata = 32'h00000055; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 12'h004;
        @(negedge PCLK);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("rw_bvalid", s_bvalid, 1'b1);
        check("rw_rdata_old", s_rdata, 32'hDEADBEEF);
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge PCLK);
        s_bready = 1'b0; s_rready = 1'b0;
        do_read("rd_rw_new", 12'h004, 32'h00000055, 2'b00);

        // Reset while a response is pending
        send_aw_w(12'h010, 32'h77, 4'hF);
        check("prerst_bvalid", s_bvalid, 1'b1);
        PRESET = 1'b1;
        #1;
        check("midrst_bvalid", s_bvalid, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("postrst_bvalid", s_bvalid, 1'b0);
        check("postrst_readies", {s_awready, s_wready, s_arready}, 3'b111);
        for (int i = 0; i < DEPTH; i++) begin
            do_read("postrst_word", ADDR_W'(i * 4), 32'h0, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
